fetch_sequencer: RTL



---
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response and the
// decode-side valid/ready instruction channel.
//   master : the fetch sequencer (drives requests, presents instructions)
//   slave  : memory + decode side (drives responses, accepts instructions)
interface fetch_sequencer_if ();
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Owns the program counter, issues one word-indexed memory request at a time,
// and presents each fetched instruction to decode with a valid/ready handshake.
// Branch redirects replace the PC; responses to requests issued before a
// redirect are dropped. Fetching halts (done) once the PC word index reaches
// NUM_INST, until a redirect restarts it.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            permits fetching (sampled in idle and when leaving hold)
//   redirect_valid/pc single-cycle redirect strobe and byte target
//   bus               imem request/response and decode instruction channel
//   done              PC ran past the program; fetching halted
//   fetch_count       instructions accepted by decode (wrapping)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_INST = 64,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  fetch_sequencer_if.master    bus,
  output logic                 done,
  output logic [COUNT_W-1:0]   fetch_count
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StHold,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                inst_valid_q, inst_valid_d;
  logic [31:0]         inst_q, inst_d;
  logic [31:0]         inst_pc_q, inst_pc_d;
  logic                done_q, done_d;
  logic [COUNT_W-1:0]  count_q, count_d;

  logic        imem_req;
  logic        in_range;
  logic        handshake;
  logic [31:0] redirect_tgt;

  assign in_range     = {2'b00, pc_q[31:2]} < NUM_INST;
  assign handshake    = inst_valid_q && bus.inst_ready;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    done_d       = done_q;
    count_d      = count_q;
    imem_req     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (enable) begin
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (in_range) begin
          // The request for the current pc goes out even under a redirect;
          // its response is then marked stale.
          imem_req = 1'b1;
          state_d  = StWait;
          if (redirect_valid) begin
            pc_d   = redirect_tgt;
            drop_d = 1'b1;
          end
        end else if (redirect_valid) begin
          // Nothing issued for an out-of-range pc; retry from the new target.
          pc_d = redirect_tgt;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

      StWait: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (bus.imem_rsp_valid) begin
            // The outstanding request just returned, so nothing is left stale.
            drop_d  = 1'b0;
            state_d = StIssue;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StIssue;
          end else begin
            inst_d       = bus.imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        if (handshake) begin
          count_d = count_q + COUNT_W'(1);
        end
        if (redirect_valid) begin
          // Held instruction is squashed unless it was accepted this cycle.
          pc_d         = redirect_tgt;
          inst_valid_d = 1'b0;
          state_d      = StIssue;
        end else if (handshake) begin
          inst_valid_d = 1'b0;
          state_d      = enable ? StIssue : StIdle;
        end
      end

      StDone: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          done_d  = 1'b0;
          state_d = StIssue;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = imem_req ? {2'b00, pc_q[31:2]} : 32'h0;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign done           = done_q;
  assign fetch_count    = count_q;

endmodule
